vc_regfile_scrubber: RTL
========================

Name: vc_regfile_scrubber

Overview:
- Initiator-side sequencer that drives the read and write ports of a 1r1w register file instance.
- On a start request it walks every entry in order.
- In dump mode it streams each entry out over a val/rdy interface before overwriting it with a clear value.
- Used on security-domain switches to export, then erase, architectural register state so nothing leaks to the next domain.

Parameters:
- p_data_nbits, 32, width of each register file entry
- p_num_entries, 32, number of entries to scrub; need not be a power of two; minimum 1
- p_clear_value, 0, value written into every entry; truncated to p_data_nbits
- c_addr_nbits, $clog2(p_num_entries), local constant; minimum 1 bit even when p_num_entries=1

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- start_val  input  1  scrub request valid
- start_rdy  output  1  scrub request ready; high only in IDLE
- start_dump  input  1  sampled with start handshake: 1 = dump each entry before clearing, 0 = clear only
- rf_read_addr  output  c_addr_nbits  register file read address
- rf_read_data  input  p_data_nbits  register file combinational read data
- rf_write_en  output  1  register file write enable
- rf_write_addr  output  c_addr_nbits  register file write address
- rf_write_data  output  p_data_nbits  register file write data; always p_clear_value
- dump_val  output  1  dumped entry valid
- dump_rdy  input  1  dump consumer ready
- dump_addr  output  c_addr_nbits  index of dumped entry
- dump_data  output  p_data_nbits  contents of dumped entry
- busy  output  1  high in SCRUB and DONE; the datapath must not write the register file while high
- done  output  1  one-cycle pulse on scrub completion

Behaviour:
- State: FSM {IDLE, SCRUB, DONE}, index register idx, mode flag dump_q.
- Reset (reset==0, asynchronous): state=IDLE, idx=0, dump_q=0.
  - Outputs while in reset: start_rdy=1; rf_write_en, dump_val, busy and done all 0; addresses 0.
  - Reset mid-scrub aborts immediately. Entries already written stay cleared; remaining entries are untouched. No done pulse.
- IDLE:
  - start_rdy=1, busy=0, rf_write_en=0, dump_val=0.
  - start_val&&start_rdy: dump_q<=start_dump, idx<=0, go to SCRUB.
- SCRUB:
  - start_rdy=0 (start_val ignored), busy=1.
  - rf_read_addr = rf_write_addr = dump_addr = idx.
  - dump_data = rf_read_data (combinational pass-through).
  - dump_q=1:
    - dump_val=1.
    - rf_write_en = dump_rdy; the entry is cleared on the same edge as the dump handshake.
    - dump_val stays high and dump_data stays stable until dump_rdy; the entry is unchanged until its handshake.
  - dump_q=0: dump_val=0, rf_write_en=1 every cycle; dump_rdy ignored.
  - Entry completes when rf_write_en=1:
    - If idx==p_num_entries-1: idx<=0, go to DONE.
    - Otherwise idx<=idx+1.
  - idx never reaches p_num_entries; no wrap beyond the last entry.
- DONE: done=1, busy=1, rf_write_en=0, dump_val=0, start_rdy=0; next cycle go to IDLE.
- Latency from the start handshake edge to the done pulse:
  - Clear-only mode: exactly p_num_entries cycles in SCRUB, then 1 DONE cycle.
  - Dump mode: p_num_entries plus the number of cycles with dump_rdy=0.
- Earliest restart: the cycle after DONE. Back-to-back scrubs are legal.
- p_num_entries=1: SCRUB lasts one completing cycle, then DONE.
- Assertions (checked only when reset==1):
  - start_val and start_dump are not X in IDLE.
  - dump_rdy is not X in SCRUB when dump_q=1.
  - idx < p_num_entries.

Test Plan:
- Setup: p_data_nbits=8, p_num_entries=4, p_clear_value=0; regfile preloaded with entries 0..3 = 0x11, 0x22, 0x33, 0x44.
- Clear-only: start_val=1, start_dump=0 for one cycle -> rf_write_en high for 4 cycles at addresses 0,1,2,3, data 0x00; done pulses on cycle 5; all entries read back 0x00; dump_val never asserted.
- Dump with dump_rdy tied 1 -> dump transfers (0,0x11), (1,0x22), (2,0x33), (3,0x44) on consecutive cycles; each entry becomes 0x00 on its handshake edge; done one cycle after the last transfer.
- Dump with backpressure: dump_rdy=0 for 3 cycles on entry 2 -> dump_val held with dump_addr=2, dump_data=0x33 stable; entry 2 still reads 0x33 and rf_write_en=0 until dump_rdy=1; done delayed exactly 3 cycles versus the previous case.
- Reset mid-scrub: assert reset after entry 1 is cleared (clear-only) -> state returns to IDLE asynchronously; entries read 0x00, 0x00, 0x33, 0x44; no done pulse; start_rdy=1.
- Busy and restart: start_val held high throughout -> start_rdy=0 during SCRUB/DONE; second scrub starts the cycle after DONE; p_clear_value=0xA5 variant leaves every entry at 0xA5.
- p_num_entries=1 with dump_q=1: one transfer (0, preload value), then done the next cycle.

Source files
------------

// File: rtl/vc_regfile_scrubber.sv
// Purpose: walks every entry of a 1r1w register file, optionally dumping it over val/rdy, then writes the clear value.
// Latency: start handshake edge to done pulse = p_num_entries + dump stall cycles + 1 (DONE cycle).
// Backpressure: in dump mode an entry is neither written nor advanced past while dump_rdy is low.
module vc_regfile_scrubber #(
  parameter int unsigned               p_data_nbits  = 32,
  parameter int unsigned               p_num_entries = 32,
  parameter logic [p_data_nbits-1:0]   p_clear_value = '0,
  localparam int unsigned              c_addr_nbits  = (p_num_entries > 1) ? $clog2(p_num_entries) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_val,
  output logic                     start_rdy,
  input  logic                     start_dump,
  output logic [c_addr_nbits-1:0]  rf_read_addr,
  input  logic [p_data_nbits-1:0]  rf_read_data,
  output logic                     rf_write_en,
  output logic [c_addr_nbits-1:0]  rf_write_addr,
  output logic [p_data_nbits-1:0]  rf_write_data,
  output logic                     dump_val,
  input  logic                     dump_rdy,
  output logic [c_addr_nbits-1:0]  dump_addr,
  output logic [p_data_nbits-1:0]  dump_data,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCRUB = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [c_addr_nbits-1:0] c_last_idx = c_addr_nbits'(p_num_entries - 1);

  state_e                    state_q, state_d;
  logic [c_addr_nbits-1:0]   idx_q, idx_d;
  logic                      dump_q, dump_d;
  logic                      entry_done;

  // An entry retires on the cycle it is written; in dump mode that is the dump handshake cycle.
  assign entry_done = (state_q == SCRUB) && (!dump_q || dump_rdy);

  // State, index and mode registers; reset aborts any scrub in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dump_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dump_q  <= dump_d;
    end
  end

  // Next-state: accept a request in IDLE, step through entries, spend one cycle in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dump_d  = dump_q;
    unique case (state_q)
      IDLE: begin
        if (start_val) begin
          state_d = SCRUB;
          idx_d   = '0;
          dump_d  = start_dump;
        end
      end
      SCRUB: begin
        if (entry_done) begin
          if (idx_q == c_last_idx) begin
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: handshake/status flags per state; write enable follows entry retirement.
  always_comb begin
    start_rdy   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    rf_write_en = 1'b0;
    dump_val    = 1'b0;
    unique case (state_q)
      IDLE: begin
        start_rdy = 1'b1;
      end
      SCRUB: begin
        busy        = 1'b1;
        rf_write_en = entry_done;
        dump_val    = dump_q;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        start_rdy = 1'b0;
      end
    endcase
  end

  // The same index addresses read, write and dump; idx is 0 whenever idle.
  assign rf_read_addr  = idx_q;
  assign rf_write_addr = idx_q;
  assign dump_addr     = idx_q;
  assign rf_write_data = p_clear_value;
  assign dump_data     = rf_read_data;

  // Input sanity and index range while out of reset.
  a_start_known: assert property (@(posedge clk) disable iff (!reset)
    (state_q == IDLE) |-> !$isunknown({start_val, start_dump}));
  a_dump_rdy_known: assert property (@(posedge clk) disable iff (!reset)
    (state_q == SCRUB && dump_q) |-> !$isunknown(dump_rdy));
  a_idx_range: assert property (@(posedge clk) disable iff (!reset)
    32'(idx_q) < p_num_entries);

endmodule
